// File: rtl/project_types.sv
// Shared core types, plus the instruction line-buffer state and sizing.
package project_types;

  typedef logic [31:0] inst_t;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic CHIP_ENABLE = 1'b1;

  localparam int LINE_WORDS_DEFAULT = 4;

  typedef enum logic {
    IROM_IDLE,
    IROM_FILL
  } irom_state_t;

endpackage

// File: rtl/i_instbus.sv
// Fetch-stage instruction bus: address out, instruction back the same cycle.
interface i_instbus;
  import project_types::*;

  logic  en;
  logic  [31:0] addr;
  inst_t data;

  modport master (output en, output addr, input data);
  modport slave  (input en, input addr, output data);

endinterface

// File: rtl/irom_fill_ctrl.sv
// Line-fill FSM: word counter, latched fill tag and backing-memory handshake.
module irom_fill_ctrl
  import project_types::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int IDX_W      = $clog2(LINE_WORDS),
  parameter int TAG_W      = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss,
  input  logic [TAG_W-1:0] tag,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic             busy,
  output logic             start,
  output logic             wr_en,
  output logic             done,
  output logic [IDX_W-1:0] cnt,
  output logic [TAG_W-1:0] fill_tag
);

  irom_state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= IROM_IDLE;
      cnt      <= '0;
      fill_tag <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        fill_tag <= tag;
        cnt      <= '0;
      end else if (wr_en) begin
        cnt <= cnt + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_addr  = '0;
    start     = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IROM_IDLE: begin
        if (miss) begin
          start     = 1'b1;
          state_nxt = IROM_FILL;
        end
      end
      IROM_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {fill_tag, cnt, 2'b00};
        if (mem_ack) begin
          wr_en = 1'b1;
          if (cnt == IDX_W'(LINE_WORDS - 1)) begin
            done      = 1'b1;
            state_nxt = IROM_IDLE;
          end
        end
      end
      default: state_nxt = IROM_IDLE;
    endcase
  end

  assign busy = (state == IROM_FILL);

endmodule

// File: rtl/irom_line_buffer.sv
// One-line instruction buffer: zero-latency hits, burst fill on miss.
// Define IROM_STATS_EN to add the miss_cnt port and counter.
module irom_line_buffer
  import project_types::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  i_instbus.slave     rom,
  output logic        stallreq,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef IROM_STATS_EN
  ,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_W = 30 - IDX_W;

  logic [TAG_W-1:0] tag, line_tag, fill_tag;
  logic [IDX_W-1:0] word, cnt;
  logic             line_valid;
  logic             hit, miss;
  logic             busy, start, wr_en, done;
  inst_t            line [LINE_WORDS];

  assign tag  = rom.addr[31:IDX_W+2];
  assign word = rom.addr[IDX_W+1:2];

  assign hit  = (rom.en == CHIP_ENABLE) && line_valid && (tag == line_tag);
  assign miss = (rom.en == CHIP_ENABLE) && !hit;

  assign stallreq = miss || busy;
  assign rom.data = (hit && !busy) ? line[word] : '0;

  irom_fill_ctrl #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_fill (
    .clk      (clk),
    .rst      (rst),
    .miss     (miss),
    .tag      (tag),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .busy     (busy),
    .start    (start),
    .wr_en    (wr_en),
    .done     (done),
    .cnt      (cnt),
    .fill_tag (fill_tag)
  );

  always_ff @(posedge clk) begin
    if (wr_en) line[cnt] <= mem_rdata;
  end

  // The line becomes valid only once its last word has landed.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      line_valid <= 1'b0;
      line_tag   <= '0;
    end else if (done) begin
      line_valid <= 1'b1;
      line_tag   <= fill_tag;
    end
  end

`ifdef IROM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) miss_cnt <= '0;
    else if (start)        miss_cnt <= miss_cnt + 32'd1;
  end
`endif

endmodule
